// File: rtl/logic_unit_if.sv
// Handshake bundle for logic_unit_pipe: upstream operand side and downstream result side.
interface logic_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;
  logic             err;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, zero, parity, err, op_count
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, zero, parity, err, op_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered eight-opcode bitwise logic unit with valid/ready on both sides
// and a saturating count of results handed downstream.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  logic_unit_if.slave  bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_ready;
  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] res;
  logic             res_err;

  // Single output register: a slot frees up only when the current result leaves.
  assign in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;
  assign xfer     = out_valid_q & bus.out_ready;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (bus.op)
      3'b000:  res = bus.a & bus.b;
      3'b001:  res = bus.a | bus.b;
      3'b010:  res = ~bus.a;
      3'b011:  res = bus.a ^ bus.b;
      3'b100:  res = ~(bus.a & bus.b);
      3'b101:  res = ~(bus.a | bus.b);
      3'b110:  res = ~(bus.a ^ bus.b);
      default: begin
        res     = '0;
        res_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    if (xfer && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (accept) begin
      out_valid_d = 1'b1;
      y_d         = res;
      zero_d      = (res == '0);
      parity_d    = ^res;
      err_d       = res_err;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
  assign bus.err       = err_q;
  assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomized bench for logic_unit_pipe: a transaction-level model (queue of
// expected results, saturating integer counters) checked every cycle.
module tb_logic_unit_pipe;

  logic clk;
  logic rst;

  logic_unit_if #(.WIDTH(8), .CNT_W(16)) bus0 ();
  logic_unit_if #(.WIDTH(8), .CNT_W(2))  bus1 ();

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  logic_unit_pipe #(.WIDTH(8), .CNT_W(2))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  bit        m_valid;
  bit [7:0]  m_y;
  bit        m_zero, m_par, m_err;
  int        m_cnt, m_cnt2;
  bit [7:0]  sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit [7:0] ref_op(input bit [7:0] a, input bit [7:0] b, input bit [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return a ^ b;
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model,
  // then return 1 time unit after the edge.
  task automatic cyc(input bit iv, input bit [7:0] ia, input bit [7:0] ib,
                     input bit [2:0] iop, input bit ordy, input bit irst);
    bit acc, xfer;
    bit [7:0] exp_y;
    rst            = irst;
    bus0.in_valid  = iv;   bus1.in_valid  = iv;
    bus0.a         = ia;   bus1.a         = ia;
    bus0.b         = ib;   bus1.b         = ib;
    bus0.op        = iop;  bus1.op        = iop;
    bus0.out_ready = ordy; bus1.out_ready = ordy;
    #1;
    chk("in_ready",   bus0.in_ready,  32'(!m_valid || ordy));
    chk("out_valid",  bus0.out_valid, 32'(m_valid));
    chk("y",          bus0.y,         32'(m_y));
    chk("zero",       bus0.zero,      32'(m_zero));
    chk("parity",     bus0.parity,    32'(m_par));
    chk("err",        bus0.err,       32'(m_err));
    chk("op_count",   bus0.op_count,  32'(m_cnt));
    chk("op_count2",  bus1.op_count,  32'(m_cnt2));
    chk("out_valid2", bus1.out_valid, 32'(m_valid));

    if (irst) begin
      m_valid = 0; m_y = 0; m_zero = 1; m_par = 0; m_err = 0;
      m_cnt = 0; m_cnt2 = 0;
      sb_q.delete();
    end else begin
      xfer = m_valid && ordy;
      acc  = iv && (!m_valid || ordy);
      if (xfer) begin
        if (sb_q.size() == 0) begin
          chk("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_y = sb_q.pop_front();
          chk("sb_y", bus0.y, 32'(exp_y));
        end
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (acc) begin
        m_y     = ref_op(ia, ib, iop);
        m_err   = (iop == 3'd7);
        m_zero  = (m_y == 8'h00);
        m_par   = ($countones(m_y) % 2) == 1;
        m_valid = 1;
        sb_q.push_back(m_y);
      end else if (xfer) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp2 [8];
  logic [1:0] exp5 [5];
  int         cnt_before;

  initial begin
    exp2 = '{8'hC0, 8'hFC, 8'h0F, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h00};
    exp5 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    m_valid = 0; m_y = 0; m_zero = 1; m_par = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
    rst = 1'b1;
    bus0.in_valid = 0; bus0.a = 0; bus0.b = 0; bus0.op = 0; bus0.out_ready = 0;
    bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.op = 0; bus1.out_ready = 0;
    @(posedge clk); #1;

    // Reset state
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 8'h12, 8'h34, 0, 1, 1);
    #1;
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_y",         bus0.y,         0);
    chk("rst_zero",      bus0.zero,      1);
    chk("rst_op_count",  bus0.op_count,  0);
    rst = 1'b0; bus0.in_valid = 0; bus1.in_valid = 0; #1;
    chk("rst_in_ready",  bus0.in_ready,  1);

    // All opcodes on fixed operands
    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'hF0, 8'hCC, 3'(i), 1, 0);
      chk($sformatf("op%0d_y", i),   bus0.y,         32'(exp2[i]));
      chk($sformatf("op%0d_v", i),   bus0.out_valid, 1);
      chk($sformatf("op%0d_z", i),   bus0.zero,      32'(i == 7));
      chk($sformatf("op%0d_p", i),   bus0.parity,    0);
      chk($sformatf("op%0d_e", i),   bus0.err,       32'(i == 7));
    end
    cyc(0, 0, 0, 0, 1, 0);

    // Backpressure
    cyc(1, 8'hAA, 8'h55, 3'd1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("bp_y",         bus0.y,         32'hFF);
      chk("bp_out_valid", bus0.out_valid, 1);
      bus0.out_ready = 0; #1;
      chk("bp_in_ready",  bus0.in_ready,  0);
    end
    cnt_before = int'(bus0.op_count);
    cyc(0, 0, 0, 0, 1, 0);
    chk("bp_release_cnt", bus0.op_count, 32'(cnt_before + 1));
    chk("bp_release_v",   bus0.out_valid, 0);
    chk("bp_hold_y",      bus0.y,         32'hFF);

    // Streaming throughput
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1, 0);
      chk("stream_valid", bus0.out_valid, 1);
    end
    cyc(0, 0, 0, 0, 1, 0);
    chk("stream_count", bus0.op_count, 16);

    // Saturation on the narrow counter
    cyc(0, 0, 0, 0, 1, 1);
    cyc(1, 8'h01, 8'h02, 3'd1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'($urandom), 8'($urandom), 3'd3, 1, 0);
      chk($sformatf("sat_%0d", i), bus1.op_count, 32'(exp5[i]));
    end

    // Reset with a pending result
    cyc(1, 8'h0F, 8'hF0, 3'd1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pend_valid", bus0.out_valid, 1);
    cyc(1, 8'h33, 8'h44, 3'd0, 0, 1);
    chk("midrst_valid", bus0.out_valid, 0);
    chk("midrst_count", bus0.op_count,  0);

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      cyc(bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
          3'($urandom_range(0, 7)), bit'($urandom_range(0, 3) != 0),
          ($urandom_range(0, 99) == 0));
    end
    cyc(0, 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
